hazard_scoreboard: RTL and testbench

Parametrised in-flight destination tracker for the pipelined RV32I core. It sits beside the ID stage and consumes the per-operand "source used" flags from the decode controller. It records the destination register of every instruction between EX and WB, selects the bypass source for each ID operand, and raises load-use (or, in no-bypass mode, any RAW) stalls. It also keeps a saturating stall-cycle counter for the performance display.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/hazard_match.sv | 45 ++++
 rtl/hazard_scoreboard.sv | 99 +++++++++
 tb/tb_hazard_scoreboard.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the ID-stage hazard scoreboard.
// Entries store rd zero-extended to RD_MAX_W so one struct serves any REG_AW.
package hazard_pkg;

    localparam int RD_MAX_W = 8;
    localparam int FWD_RF   = 0;

    typedef struct packed {
        logic                v;
        logic [RD_MAX_W-1:0] rd;
        logic                we;
        logic                ld;
    } ent_t;

    function automatic int fwd_w(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand priority comparator: youngest matching stage and hazard flag.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1,
    parameter int FW         = fwd_w(STAGES)
) (
    input  logic                valid_i,
    input  logic                used_i,
    input  logic [RD_MAX_W-1:0] addr_i,
    input  ent_t                ent_i [1:STAGES],
    output logic [FW-1:0]       m_o,
    output logic                hazard_o
);

    logic ld;

    // Oldest-to-youngest scan so the lowest matching stage wins.
    always_comb begin
        m_o = FW'(FWD_RF);
        ld  = 1'b0;
        for (int k = STAGES; k >= 1; k--) begin
            if (valid_i && used_i && (addr_i != '0) &&
                ent_i[k].v && ent_i[k].we &&
                (ent_i[k].rd == addr_i)) begin
                m_o = FW'(k);
                ld  = ent_i[k].ld;
            end
        end
    end

    always_comb begin
        hazard_o = 1'b0;
        if (m_o != '0) begin
            if (FWD_EN != 0) begin
                hazard_o = ld && (int'(m_o) < LOAD_READY);
            end else begin
                hazard_o = int'(m_o) < STAGES;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// In-flight destination tracker: bypass select, load-use/RAW stall,
// and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int STAGES     = 3,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid,
    input  logic [REG_AW-1:0]          id_r1_addr,
    input  logic [REG_AW-1:0]          id_r2_addr,
    input  logic                       id_r1_used,
    input  logic                       id_r2_used,
    input  logic [REG_AW-1:0]          id_rd_addr,
    input  logic                       id_rd_we,
    input  logic                       id_is_load,
    input  logic                       flush,
    output logic                       stall,
    output logic [fwd_w(STAGES)-1:0]   fwd_sel_r1,
    output logic [fwd_w(STAGES)-1:0]   fwd_sel_r2,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int FW = fwd_w(STAGES);

    ent_t             ent_q [1:STAGES];
    ent_t             ent_d [1:STAGES];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [FW-1:0]    m1;
    logic [FW-1:0]    m2;
    logic             haz1;
    logic             haz2;

    hazard_match #(
        .STAGES(STAGES), .LOAD_READY(LOAD_READY),
        .FWD_EN(FWD_EN), .FW(FW)
    ) u_match_r1 (
        .valid_i (id_valid),
        .used_i  (id_r1_used),
        .addr_i  (RD_MAX_W'(id_r1_addr)),
        .ent_i   (ent_q),
        .m_o     (m1),
        .hazard_o(haz1)
    );

    hazard_match #(
        .STAGES(STAGES), .LOAD_READY(LOAD_READY),
        .FWD_EN(FWD_EN), .FW(FW)
    ) u_match_r2 (
        .valid_i (id_valid),
        .used_i  (id_r2_used),
        .addr_i  (RD_MAX_W'(id_r2_addr)),
        .ent_i   (ent_q),
        .m_o     (m2),
        .hazard_o(haz2)
    );

    assign stall      = (haz1 | haz2) & ~flush;
    assign fwd_sel_r1 = (stall || FWD_EN == 0) ? FW'(FWD_RF) : m1;
    assign fwd_sel_r2 = (stall || FWD_EN == 0) ? FW'(FWD_RF) : m2;
    assign stall_cnt  = cnt_q;

    always_comb begin
        ent_d[1] = '0;
        if (id_valid && !stall && !flush) begin
            ent_d[1] = '{v: 1'b1, rd: RD_MAX_W'(id_rd_addr),
                         we: id_rd_we, ld: id_is_load};
        end
        for (int k = 2; k <= STAGES; k++) begin
            ent_d[k] = ent_q[k-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 1; k <= STAGES; k++) begin
                ent_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: bypass instance (defaults) and no-bypass 4-bit-counter
// instance driven by the same ID stream.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_r1_addr;
    logic [4:0]  id_r2_addr;
    logic        id_r1_used;
    logic        id_r2_used;
    logic [4:0]  id_rd_addr;
    logic        id_rd_we;
    logic        id_is_load;
    logic        flush;

    logic        a_stall;
    logic [1:0]  a_f1;
    logic [1:0]  a_f2;
    logic [31:0] a_cnt;
    logic        b_stall;
    logic [1:0]  b_f1;
    logic [1:0]  b_f2;
    logic [3:0]  b_cnt;

    int n_vec = 0;
    int n_err = 0;

    hazard_scoreboard dut_a (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .flush(flush),
        .stall(a_stall), .fwd_sel_r1(a_f1), .fwd_sel_r2(a_f2),
        .stall_cnt(a_cnt)
    );

    hazard_scoreboard #(.FWD_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used),
        .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .id_is_load(id_is_load), .flush(flush),
        .stall(b_stall), .fwd_sel_r1(b_f1), .fwd_sel_r2(b_f2),
        .stall_cnt(b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] r1;
        logic       u1;
        logic [4:0] r2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       fl;
        logic       st;
        logic [1:0] f1;
        logic [1:0] f2;
        int         cnt;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    function automatic vec_t mk(
        input logic v, input int r1, input logic u1,
        input int r2, input logic u2, input int rd,
        input logic we, input logic ld, input logic fl,
        input logic st, input int f1, input int f2, input int cnt);
        vec_t t;
        t.v = v; t.r1 = 5'(r1); t.u1 = u1;
        t.r2 = 5'(r2); t.u2 = u2; t.rd = 5'(rd);
        t.we = we; t.ld = ld; t.fl = fl;
        t.st = st; t.f1 = 2'(f1); t.f2 = 2'(f2); t.cnt = cnt;
        return t;
    endfunction

    task automatic drive(
        input logic v, input int r1, input logic u1,
        input int r2, input logic u2, input int rd,
        input logic we, input logic ld, input logic fl);
        id_valid   = v;
        id_r1_addr = 5'(r1);
        id_r1_used = u1;
        id_r2_addr = 5'(r2);
        id_r2_used = u2;
        id_rd_addr = 5'(rd);
        id_rd_we   = we;
        id_is_load = ld;
        flush      = fl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1, 5, 1, 6, 1, 7, 1, 0, 0);
        #1;
        chk("rst_stall", 32'(a_stall), 0);
        chk("rst_f1", 32'(a_f1), 0);
        chk("rst_f2", 32'(a_f2), 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        tv[0]  = mk(1,  1, 1,  2, 1,  5, 1, 0, 0,  0, 0, 0, 0);
        tv[1]  = mk(1,  5, 1,  5, 1,  6, 1, 0, 0,  0, 1, 1, 0);
        tv[2]  = mk(1,  5, 1,  6, 1,  9, 1, 0, 0,  0, 2, 1, 0);
        tv[3]  = mk(1,  5, 1,  0, 1, 10, 1, 0, 0,  0, 3, 0, 0);
        tv[4]  = mk(1,  1, 1,  7, 0,  7, 1, 1, 0,  0, 0, 0, 0);
        tv[5]  = mk(1,  7, 1,  0, 1,  8, 1, 0, 0,  1, 0, 0, 0);
        tv[6]  = mk(1,  7, 1,  0, 1,  8, 1, 0, 0,  0, 2, 0, 1);
        tv[7]  = mk(1,  0, 1,  0, 0,  0, 1, 0, 0,  0, 0, 0, 1);
        tv[8]  = mk(1,  0, 1,  0, 1, 11, 1, 0, 0,  0, 0, 0, 1);
        tv[9]  = mk(1,  8, 1,  8, 0, 12, 1, 0, 0,  0, 3, 0, 1);
        tv[10] = mk(1,  0, 1,  0, 0, 12, 1, 0, 0,  0, 0, 0, 1);
        tv[11] = mk(1, 12, 1, 11, 1, 13, 1, 0, 0,  0, 1, 3, 1);
        tv[12] = mk(0, 13, 1, 13, 1, 13, 1, 0, 0,  0, 0, 0, 1);
        tv[13] = mk(1, 13, 1, 12, 1, 13, 0, 0, 0,  0, 2, 3, 1);
        tv[14] = mk(1, 13, 1,  0, 0, 15, 1, 0, 0,  0, 3, 0, 1);
        tv[15] = mk(1,  0, 1,  0, 0, 14, 1, 1, 0,  0, 0, 0, 1);
        tv[16] = mk(1,  0, 1,  0, 0, 16, 1, 1, 0,  0, 0, 0, 1);
        tv[17] = mk(1, 16, 1, 14, 1, 17, 1, 0, 0,  1, 0, 0, 1);
        tv[18] = mk(1, 16, 1, 14, 1, 17, 1, 0, 0,  0, 2, 3, 2);
        tv[19] = mk(1,  0, 1,  0, 0, 18, 1, 1, 0,  0, 0, 0, 2);
        tv[20] = mk(1, 18, 1,  0, 1, 19, 1, 0, 1,  0, 1, 0, 2);
        tv[21] = mk(1, 18, 1, 17, 1, 20, 1, 0, 0,  0, 2, 3, 2);
        tv[22] = mk(0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 0, 2);

        rst = 1'b1;
        idle();
        do_reset();

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].v, int'(tv[i].r1), tv[i].u1, int'(tv[i].r2),
                  tv[i].u2, int'(tv[i].rd), tv[i].we, tv[i].ld,
                  tv[i].fl);
            @(negedge clk);
            chk($sformatf("v%0d_stall", i), 32'(a_stall), 32'(tv[i].st));
            chk($sformatf("v%0d_f1", i), 32'(a_f1), 32'(tv[i].f1));
            chk($sformatf("v%0d_f2", i), 32'(a_f2), 32'(tv[i].f2));
            chk($sformatf("v%0d_cnt", i), a_cnt, 32'(tv[i].cnt));
        end

        // No-bypass: dependent behind producer stalls two cycles.
        do_reset();
        @(posedge clk);
        #1;
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0);
        @(negedge clk);
        chk("nb_prod_stall", 32'(b_stall), 0);
        @(posedge clk);
        #1;
        drive(1, 5, 1, 5, 1, 6, 1, 0, 0);
        @(negedge clk);
        chk("nb_dep1_stall", 32'(b_stall), 1);
        chk("nb_dep1_a_f1", 32'(a_f1), 1);
        chk("nb_dep1_a_stall", 32'(a_stall), 0);
        @(posedge clk);
        @(negedge clk);
        chk("nb_dep2_stall", 32'(b_stall), 1);
        chk("nb_dep2_f1", 32'(b_f1), 0);
        @(posedge clk);
        @(negedge clk);
        chk("nb_rel_stall", 32'(b_stall), 0);
        chk("nb_rel_f1", 32'(b_f1), 0);
        chk("nb_rel_f2", 32'(b_f2), 0);
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("nb_cnt", 32'(b_cnt), 2);

        // Asynchronous reset in the middle of a load-use stall.
        do_reset();
        @(posedge clk);
        #1;
        drive(1, 1, 1, 0, 0, 7, 1, 1, 0);
        @(posedge clk);
        #1;
        drive(1, 7, 1, 0, 1, 8, 1, 0, 0);
        @(negedge clk);
        chk("ar_pre_stall", 32'(a_stall), 1);
        #1;
        rst = 1'b1;
        #1;
        chk("ar_stall", 32'(a_stall), 0);
        chk("ar_b_stall", 32'(b_stall), 0);
        chk("ar_f1", 32'(a_f1), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ar_post_stall", 32'(a_stall), 0);
        chk("ar_post_f1", 32'(a_f1), 0);
        chk("ar_post_cnt", a_cnt, 0);

        // Counter saturation on the 4-bit no-bypass instance.
        do_reset();
        @(posedge clk);
        #1;
        drive(1, 5, 1, 5, 1, 5, 1, 0, 0);
        repeat (30) @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("sat_b_cnt", 32'(b_cnt), 15);
        chk("sat_a_cnt", a_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
